// File: rtl/lpc_pkg.sv
// Shared LPC I/O target definitions: decoder states, cycle-type and SYNC codes,
// register offsets and the line-status register layout.
package lpc_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CTDIR,
        ADDR0,
        ADDR1,
        ADDR2,
        ADDR3,
        WDATA0,
        WDATA1,
        TAR_H,
        TAR_T,
        SYNC,
        RDATA0,
        RDATA1,
        TAR1_D,
        TAR1_R
    } lpc_state_t;

    localparam logic [3:0] CT_IO_READ  = 4'h0;
    localparam logic [3:0] CT_IO_WRITE = 4'h2;

    localparam logic [3:0] SYNC_READY = 4'h0;
    localparam logic [3:0] SYNC_LWAIT = 4'h6;
    localparam logic [3:0] SYNC_ERR   = 4'hA;
    localparam logic [3:0] TAR_DRIVE  = 4'hF;

    localparam logic [2:0] OFS_DATA    = 3'd0;
    localparam logic [2:0] OFS_LSR     = 3'd5;
    localparam logic [2:0] OFS_SCRATCH = 3'd7;

    function automatic logic [7:0] lsr_pack(input logic rx_nonempty, input logic overrun,
                                            input logic tx_not_full, input logic tx_empty);
        return {1'b0, tx_empty, tx_not_full, 3'b000, overrun, rx_nonempty};
    endfunction

endpackage

// File: rtl/lpc_fifo.sv
// Power-of-two FIFO with a combinational head; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module lpc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Empty FIFO presents zero rather than a stale entry.
    assign head    = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/lpc_io_target.sv
// LPC I/O-cycle target claiming an 8-byte UART-like window: data register with
// RX/TX FIFOs, line-status register and scratch register.
module lpc_io_target
    import lpc_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h03F8,
    parameter int          RX_DEPTH  = 16,
    parameter int          TX_DEPTH  = 16,
    parameter int          LWAIT_MAX = 255
) (
    input  logic       lpc_clk,
    input  logic       lpc_rst,
    input  logic       lpc_frame,
    inout  wire  [3:0] lpc_data,
    output logic [7:0] tx_data,
    output logic       tx_data_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid
);
    localparam int LW_W = (LWAIT_MAX < 1) ? 1 : $clog2(LWAIT_MAX + 1);

    lpc_state_t       state_reg;
    logic             is_write_reg;
    logic [11:0]      addr_reg;
    logic [2:0]       offset_reg;
    logic [7:0]       wdata_reg;
    logic [3:0]       sync_reg;
    logic [7:0]       rdata_reg;
    logic             rd_pop_reg;
    logic [LW_W-1:0]  lwait_cnt_reg;
    logic             lad_oe_reg;
    logic [3:0]       lad_out_reg;
    logic             overrun_reg;
    logic [7:0]       scratch_reg;

    logic [7:0]                  rx_head;
    logic                        rx_full;
    logic                        rx_empty;
    logic [$clog2(RX_DEPTH):0]   rx_count;
    logic                        tx_full;
    logic                        tx_empty;
    logic [$clog2(TX_DEPTH):0]   tx_count;

    logic       commit;
    logic       tx_push;
    logic       tx_pop;
    logic       rx_pop;
    logic       lsr_clr;
    logic       overrun_set;
    logic [3:0] sync_next;
    logic [7:0] read_byte;

    assign lpc_data = lad_oe_reg ? lad_out_reg : 4'bzzzz;

    // Side effects only fire while the host keeps the cycle alive (LFRAME# high).
    assign commit      = (state_reg == SYNC) && (sync_reg == SYNC_READY) && is_write_reg && lpc_frame;
    assign tx_push     = commit && (offset_reg == OFS_DATA);
    assign rx_pop      = (state_reg == RDATA1) && lpc_frame && rd_pop_reg;
    assign lsr_clr     = (state_reg == RDATA1) && lpc_frame && !is_write_reg && (offset_reg == OFS_LSR);
    assign overrun_set = rx_data_valid && rx_full && !rx_pop;
    assign tx_data_valid = !tx_empty;
    assign tx_pop        = tx_data_valid && tx_ready;

    // A data-register write stalls with long-wait SYNCs until TX space appears.
    always_comb begin
        sync_next = SYNC_READY;
        if (is_write_reg && (offset_reg == OFS_DATA) && tx_full) begin
            sync_next = (lwait_cnt_reg == LW_W'(LWAIT_MAX)) ? SYNC_ERR : SYNC_LWAIT;
        end
    end

    always_comb begin
        case (offset_reg)
            OFS_DATA:    read_byte = rx_head;
            OFS_LSR:     read_byte = lsr_pack(rx_count != '0, overrun_reg, !tx_full, tx_count == '0);
            OFS_SCRATCH: read_byte = scratch_reg;
            default:     read_byte = 8'h00;
        endcase
    end

    always_ff @(posedge lpc_clk or negedge lpc_rst) begin
        if (!lpc_rst) begin
            state_reg     <= IDLE;
            is_write_reg  <= 1'b0;
            addr_reg      <= '0;
            offset_reg    <= '0;
            wdata_reg     <= '0;
            sync_reg      <= SYNC_READY;
            rdata_reg     <= '0;
            rd_pop_reg    <= 1'b0;
            lwait_cnt_reg <= '0;
            lad_oe_reg    <= 1'b0;
            lad_out_reg   <= '0;
        end else if (!lpc_frame) begin
            state_reg     <= (lpc_data == 4'h0) ? CTDIR : IDLE;
            lad_oe_reg    <= 1'b0;
            lwait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: state_reg <= IDLE;
                CTDIR: begin
                    if (lpc_data == CT_IO_READ || lpc_data == CT_IO_WRITE) begin
                        is_write_reg <= (lpc_data == CT_IO_WRITE);
                        state_reg    <= ADDR0;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                ADDR0: begin addr_reg[11:8] <= lpc_data; state_reg <= ADDR1; end
                ADDR1: begin addr_reg[7:4]  <= lpc_data; state_reg <= ADDR2; end
                ADDR2: begin addr_reg[3:0]  <= lpc_data; state_reg <= ADDR3; end
                ADDR3: begin
                    if ({addr_reg, lpc_data[3]} == BASE_ADDR[15:3]) begin
                        offset_reg <= lpc_data[2:0];
                        state_reg  <= is_write_reg ? WDATA0 : TAR_H;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                WDATA0: begin wdata_reg[3:0] <= lpc_data; state_reg <= WDATA1; end
                WDATA1: begin wdata_reg[7:4] <= lpc_data; state_reg <= TAR_H; end
                TAR_H: begin
                    state_reg     <= TAR_T;
                    lad_oe_reg    <= 1'b1;
                    lad_out_reg   <= TAR_DRIVE;
                    lwait_cnt_reg <= '0;
                end
                TAR_T: begin
                    state_reg     <= SYNC;
                    sync_reg      <= sync_next;
                    lad_out_reg   <= sync_next;
                    lwait_cnt_reg <= (sync_next == SYNC_LWAIT) ? lwait_cnt_reg + 1'b1 : '0;
                end
                SYNC: begin
                    if (sync_reg == SYNC_LWAIT) begin
                        sync_reg      <= sync_next;
                        lad_out_reg   <= sync_next;
                        lwait_cnt_reg <= (sync_next == SYNC_LWAIT) ? lwait_cnt_reg + 1'b1 : '0;
                    end else if (sync_reg == SYNC_READY && !is_write_reg) begin
                        state_reg   <= RDATA0;
                        rdata_reg   <= read_byte;
                        lad_out_reg <= read_byte[3:0];
                        rd_pop_reg  <= (offset_reg == OFS_DATA) && !rx_empty;
                    end else begin
                        state_reg   <= TAR1_D;
                        lad_out_reg <= TAR_DRIVE;
                    end
                end
                RDATA0: begin state_reg <= RDATA1; lad_out_reg <= rdata_reg[7:4]; end
                RDATA1: begin state_reg <= TAR1_D; lad_out_reg <= TAR_DRIVE; end
                TAR1_D: begin
                    state_reg     <= TAR1_R;
                    lad_oe_reg    <= 1'b0;
                    lwait_cnt_reg <= '0;
                end
                TAR1_R:  state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Overrun set wins over a coincident LSR-read clear.
    always_ff @(posedge lpc_clk or negedge lpc_rst) begin
        if (!lpc_rst) begin
            overrun_reg <= 1'b0;
            scratch_reg <= 8'h00;
        end else begin
            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end else if (lsr_clr) begin
                overrun_reg <= 1'b0;
            end
            if (commit && offset_reg == OFS_SCRATCH) begin
                scratch_reg <= wdata_reg;
            end
        end
    end

    lpc_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (lpc_clk),
        .rst_n     (lpc_rst),
        .push      (rx_data_valid),
        .push_data (rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

    lpc_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (lpc_clk),
        .rst_n     (lpc_rst),
        .push      (tx_push),
        .push_data (wdata_reg),
        .pop       (tx_pop),
        .head      (tx_data),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

endmodule

// File: tb/tb_lpc_io_target.sv
// Self-checking bench for lpc_io_target: an LPC host model drives I/O cycles while
// scoreboard queues hold the expected read bytes and the expected TX byte stream.
module tb_lpc_io_target;
    localparam int RXD = 16;
    localparam int TXD = 16;

    logic       lpc_clk = 1'b0;
    logic       lpc_rst;
    logic       lpc_frame;
    logic       host_oe;
    logic [3:0] host_lad;
    wire  [3:0] lpc_data;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_data_valid;

    logic [7:0] tx_q[$];
    logic [7:0] rd_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       vd, vr;

    assign lpc_data = host_oe ? host_lad : 4'bzzzz;
    always #5 lpc_clk = ~lpc_clk;

    lpc_io_target #(
        .BASE_ADDR (16'h03F8),
        .RX_DEPTH  (RXD),
        .TX_DEPTH  (TXD),
        .LWAIT_MAX (4)
    ) dut (
        .lpc_clk       (lpc_clk),
        .lpc_rst       (lpc_rst),
        .lpc_frame     (lpc_frame),
        .lpc_data      (lpc_data),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid)
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // TX scoreboard: every byte leaving the TX FIFO must match the oldest expected write.
    always @(negedge lpc_clk) begin
        #1;
        if (lpc_rst && tx_data_valid && tx_ready) begin
            if (tx_q.size() == 0) begin
                chk_val("tx_extra", 32'(tx_q.size()), 32'd1);
            end else begin
                chk_val("tx_byte", tx_data, tx_q.pop_front());
                $display("tx pop 0x%02h", tx_data);
            end
        end
    end

    task automatic drive(input logic frame, input logic [3:0] nib);
        @(negedge lpc_clk);
        lpc_frame = frame;
        host_oe   = 1'b1;
        host_lad  = nib;
    endtask

    task automatic send_hdr(input logic wr, input logic [15:0] addr);
        drive(1'b0, 4'h0);
        drive(1'b1, wr ? 4'h2 : 4'h0);
        for (int i = 3; i >= 0; i--) drive(1'b1, addr[i*4 +: 4]);
    endtask

    task automatic release_bus;
        @(negedge lpc_clk);
        host_oe = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] b);
        @(negedge lpc_clk);
        rx_data       = b;
        rx_data_valid = 1'b1;
        @(negedge lpc_clk);
        rx_data_valid = 1'b0;
    endtask

    task automatic lpc_write(input logic [15:0] addr, input logic [7:0] data,
                             input logic [3:0] exp_sync, input int exp_lw,
                             input int ready_after, input bit accepted,
                             output logic v_d, output logic v_r);
        logic [3:0] code;
        int         n6;
        if (accepted) tx_q.push_back(data);
        send_hdr(1'b1, addr);
        drive(1'b1, data[3:0]);
        drive(1'b1, data[7:4]);
        release_bus();
        @(negedge lpc_clk);
        chk_val("wr_tar", lpc_data, 4'hF);
        n6   = 0;
        code = 4'h6;
        for (int i = 0; i < 40 && code == 4'h6; i++) begin
            @(negedge lpc_clk);
            code = lpc_data;
            if (code == 4'h6) begin
                n6++;
                if (n6 == ready_after) tx_ready = 1'b1;
            end
        end
        chk_val("wr_sync", code, exp_sync);
        chk_val("wr_lwait_cycles", n6, exp_lw);
        @(negedge lpc_clk);
        chk_val("wr_tar1", lpc_data, 4'hF);
        v_d = tx_data_valid;
        @(negedge lpc_clk);
        chk_val("wr_release", dut.lad_oe_reg, 1'b0);
        v_r      = tx_data_valid;
        host_oe  = 1'b1;
        host_lad = 4'hF;
        $display("io write 0x%04h data 0x%02h sync 0x%0h lwait %0d", addr, data, code, n6);
    endtask

    task automatic lpc_read(input logic [15:0] addr, input logic [7:0] exp, input bit abort_rdata0);
        logic [3:0] code;
        logic [7:0] got;
        if (!abort_rdata0) rd_q.push_back(exp);
        send_hdr(1'b0, addr);
        release_bus();
        @(negedge lpc_clk);
        chk_val("rd_tar", lpc_data, 4'hF);
        code = 4'h6;
        for (int i = 0; i < 40 && code == 4'h6; i++) begin
            @(negedge lpc_clk);
            code = lpc_data;
        end
        chk_val("rd_sync", code, 4'h0);
        @(negedge lpc_clk);
        got = 8'h00;
        got[3:0] = lpc_data;
        if (abort_rdata0) begin
            chk_val("rd_abort_lo", got[3:0], exp[3:0]);
            lpc_frame = 1'b0;
            @(negedge lpc_clk);
            chk_val("abort_release", dut.lad_oe_reg, 1'b0);
            lpc_frame = 1'b1;
            host_oe   = 1'b1;
            host_lad  = 4'hF;
            $display("io read 0x%04h aborted in RDATA0", addr);
        end else begin
            @(negedge lpc_clk);
            got[7:4] = lpc_data;
            chk_val($sformatf("rd_%04h", addr), got, rd_q.pop_front());
            @(negedge lpc_clk);
            chk_val("rd_tar1", lpc_data, 4'hF);
            @(negedge lpc_clk);
            chk_val("rd_release", dut.lad_oe_reg, 1'b0);
            host_oe  = 1'b1;
            host_lad = 4'hF;
            $display("io read 0x%04h data 0x%02h", addr, got);
        end
    endtask

    task automatic lpc_read_unclaimed(input logic [15:0] addr);
        int driven;
        driven = 0;
        send_hdr(1'b0, addr);
        release_bus();
        if (dut.lad_oe_reg) driven++;
        for (int i = 0; i < 8; i++) begin
            @(negedge lpc_clk);
            if (dut.lad_oe_reg) driven++;
        end
        chk_val("unclaimed_drive_cycles", driven, 0);
        host_oe  = 1'b1;
        host_lad = 4'hF;
        $display("io read 0x%04h unclaimed, driven cycles %0d", addr, driven);
    endtask

    initial begin
        lpc_rst       = 1'b0;
        lpc_frame     = 1'b1;
        host_oe       = 1'b1;
        host_lad      = 4'hF;
        tx_ready      = 1'b1;
        rx_data       = 8'h00;
        rx_data_valid = 1'b0;
        repeat (3) @(negedge lpc_clk);
        chk_val("rst_tx_valid", tx_data_valid, 1'b0);
        chk_val("rst_tx_data", tx_data, 8'h00);
        chk_val("rst_lad_oe", dut.lad_oe_reg, 1'b0);
        lpc_rst = 1'b1;
        @(negedge lpc_clk);

        // Scratch register and the reserved offsets.
        lpc_read(16'h03FF, 8'h00, 1'b0);
        lpc_write(16'h03FF, 8'hA5, 4'h0, 0, -1, 1'b0, vd, vr);
        lpc_read(16'h03FF, 8'hA5, 1'b0);
        lpc_write(16'h03F9, 8'h12, 4'h0, 0, -1, 1'b0, vd, vr);
        lpc_read(16'h03F9, 8'h00, 1'b0);
        lpc_read(16'h03FE, 8'h00, 1'b0);

        // Data write flows straight out of the TX FIFO.
        lpc_write(16'h03F8, 8'h41, 4'h0, 0, -1, 1'b1, vd, vr);
        chk_val("tx_valid_after_push", vd, 1'b1);
        chk_val("tx_valid_after_pop", vr, 1'b0);

        // RX path and LSR.
        push_rx(8'h5A);
        lpc_read(16'h03FD, 8'h61, 1'b0);
        lpc_read(16'h03F8, 8'h5A, 1'b0);
        lpc_read(16'h03FD, 8'h60, 1'b0);
        lpc_read(16'h03F8, 8'h00, 1'b0);

        // Foreign window, then abort mid-RDATA0 leaves the RX byte in place.
        lpc_read_unclaimed(16'h02F8);
        push_rx(8'h77);
        lpc_read(16'h03F8, 8'h77, 1'b1);
        lpc_read(16'h03FD, 8'h61, 1'b0);
        lpc_read(16'h03F8, 8'h77, 1'b0);

        // RX overrun: one byte too many is dropped.
        for (int i = 0; i <= RXD; i++) push_rx(8'h80 + 8'(i));
        lpc_read(16'h03FD, 8'h63, 1'b0);
        lpc_read(16'h03FD, 8'h61, 1'b0);
        for (int i = 0; i < RXD; i++) lpc_read(16'h03F8, 8'h80 + 8'(i), 1'b0);
        lpc_read(16'h03FD, 8'h60, 1'b0);

        // TX full: error SYNC drops a write, then long wait resolves once the sink drains.
        tx_ready = 1'b0;
        for (int i = 0; i < TXD; i++) lpc_write(16'h03F8, 8'hC0 + 8'(i), 4'h0, 0, -1, 1'b1, vd, vr);
        lpc_read(16'h03FD, 8'h00, 1'b0);
        lpc_write(16'h03F8, 8'hEE, 4'hA, 4, -1, 1'b0, vd, vr);
        lpc_write(16'h03F8, 8'hDD, 4'h0, 4, 3, 1'b1, vd, vr);
        for (int i = 0; i < 200 && (tx_q.size() != 0 || tx_data_valid); i++) @(negedge lpc_clk);
        chk_val("tx_q_remaining", tx_q.size(), 0);
        chk_val("tx_valid_drained", tx_data_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
